matmul_uart_host: RTL and testbench
===================================

// Module: matmul_uart_host
// PURPOSE
// - Host-side initiator for the 2x2 matrix-multiply UART accelerator.
// - Accepts one 8-operand request on a valid/ready port.
// - Serialises the operands as 8 UART 8N1 bytes, then receives the 4 result bytes.
// - Returns the results on a valid/ready response port.
// - Sits in the FPGA test harness / SoC wrapper, cross-wired to the accelerator's RX/TX pins.
// PARAMETERS
// - CLKS_PER_BIT    833        clk cycles per UART bit (100 MHz / 120000 baud)
// - TX_GAP_BITS     1          extra idle-high bit times inserted after each TX stop bit
// - TIMEOUT_CYCLES  1_000_000  max cycles waiting for any result byte (only with MATMUL_HOST_TIMEOUT_EN)
// PORTS
// - clk            in   1   clock
// - rst_n          in   1   reset, synchronous, active-low
// - req_valid      in   1   request present
// - req_ready      out  1   high only in IDLE
// - req_a          in   32  {A3,A2,A1,A0}, A0 = [7:0]
// - req_b          in   32  {B3,B2,B1,B0}, B0 = [7:0]
// - uart_tx        out  1   serial line to accelerator RX; idle high
// - uart_rx        in   1   serial line from accelerator TX; externally pulled high
// - rsp_valid      out  1   result present; held until rsp_ready
// - rsp_ready      in   1   consumer accepts result
// - rsp_c          out  32  {C11,C10,C01,C00}, each byte as received
// - rsp_frame_err  out  1   valid with rsp_valid; any received stop bit sampled low
// - rsp_timeout    out  1   valid with rsp_valid; response timed out
// - busy           out  1   high in any state other than IDLE
// BEHAVIOUR
// - Reset (rst_n low at posedge):
//   - state=IDLE, uart_tx=1, req_ready=1, rsp_valid=0, rsp_c=0, rsp_frame_err=0, rsp_timeout=0, busy=0.
//   - Reset mid-transaction aborts immediately: no partial response, uart_tx high on the next cycle.
// - Accept: on req_valid&&req_ready, latch req_a/req_b and enter SEND.
//   - Start bit of byte 0 is driven on the following cycle.
// - SEND, byte order A0,A1,A2,A3,B0,B1,B2,B3:
//   - Each frame is start(0), 8 data bits LSB first, stop(1); every bit lasts exactly CLKS_PER_BIT cycles.
//   - Frame is followed by TX_GAP_BITS*CLKS_PER_BIT idle-high cycles.
//   - After the gap of byte 7, enter RECV.
// - RX synchronisation: uart_rx passes through a 2-flop synchroniser. The receiver is disabled outside RECV; bytes arriving then are dropped.
// - RECV:
//   - Start detect on synchronised 1->0; confirm low at CLKS_PER_BIT/2, else treat as a glitch and re-arm.
//   - Data sampled at each bit centre; stop sampled at its centre.
//   - Stop sampled 0 sets the sticky frame flag; the byte is still stored.
//   - Byte k (0..3) is stored into rsp_c[8k+7:8k].
//   - After byte 3's stop sample, enter RESP next cycle; no need to wait for the full stop bit.
// - RESP: rsp_valid=1 with rsp_c and flags stable until rsp_ready; on the handshake cycle go to IDLE, so req_ready=1 on the next cycle.
// - Width: results are the accelerator's low 8 bits (mod 256); no host-side arithmetic.
// - States: IDLE -> SEND -> RECV -> RESP -> IDLE. Any undefined encoding -> IDLE.
// - Counters:
//   - bit-timer 0..CLKS_PER_BIT-1, wraps per bit
//   - TX byte index 0..7
//   - RX byte index 0..3; both indices clear on entering IDLE
// CONFIGURATION
// - MATMUL_HOST_TIMEOUT_EN defined:
//   - Cycle counter cleared on entering RECV and on each completed RX byte.
//   - On reaching TIMEOUT_CYCLES, enter RESP with rsp_timeout=1.
//   - Bytes not yet received read 0 in rsp_c.
//   - An RX byte in progress at that moment is discarded.
// - MATMUL_HOST_TIMEOUT_EN undefined: no counter; RECV waits indefinitely; rsp_timeout tied 0.
// TESTING
// - Full transaction, CLKS_PER_BIT=4, line looped through accelerator model:
//   - Stimulus: A={4,3,2,1}, B={8,7,6,5}.
//   - Response: TX bytes 01..08 in order; model replies 13,16,2B,32; rsp_c=32'h322B1613, both flags 0.
// - Bit timing, CLKS_PER_BIT=4, TX_GAP_BITS=1:
//   - uart_tx falls 1 cycle after the handshake; each bit is 4 cycles; frames start 44 cycles apart.
// - Backpressure: hold rsp_ready=0 for 20 cycles after rsp_valid -> rsp_valid, rsp_c stable, req_ready=0; IDLE 1 cycle after rsp_ready.
// - RX robustness:
//   - 1-cycle low glitch on uart_rx in RECV -> ignored.
//   - Byte sent with stop=0 -> stored; rsp_frame_err=1.
//   - Bytes injected during SEND -> not stored.
// - Timeout (EN defined, TIMEOUT_CYCLES=200): model replies 2 bytes (AA,BB) then silence -> rsp_timeout=1, rsp_c=32'h0000BBAA.
// - Reset mid-SEND after 3 bytes: uart_tx=1 the cycle after reset, req_ready=1, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/matmul_uart_host_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmul_uart_host_if : request/response handshake bundle of the host      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface matmul_uart_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_c;
  logic        rsp_frame_err;
  logic        rsp_timeout;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_c, rsp_frame_err, rsp_timeout
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_c, rsp_frame_err, rsp_timeout
  );
endinterface
`default_nettype wire

// File: rtl/matmul_uart_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmul_uart_host : sends 8 operand bytes over UART 8N1, collects 4 result |
// | bytes. Optional response timeout: define MATMUL_HOST_TIMEOUT_EN.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module matmul_uart_host #(
  parameter int CLKS_PER_BIT   = 833,
  parameter int TX_GAP_BITS    = 1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  matmul_uart_host_if.slave  bus,
  output logic               uart_tx,
  input  wire logic          uart_rx,
  output logic               busy
);
  localparam int TW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TX_BITS = 10 + TX_GAP_BITS;
  localparam int XW      = $clog2(TX_BITS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_RECV = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [XW-1:0] TX_LAST   = XW'(TX_BITS - 1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q;
  logic [XW-1:0] tx_bit_q;
  logic [2:0]    tx_byte_q;
  logic [63:0]   tx_data_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          rx_active_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q;
  logic [1:0]    rx_byte_q;
  logic [31:0]   rsp_c_q;
  logic          frame_err_q;
  logic [7:0]    cur_byte;

  logic bit_end, tx_done, rx_fall, rx_stop, rx_last, timeout_hit;

  assign bit_end = (timer_q == BIT_LAST);
  assign tx_done = (state_q == S_SEND) && bit_end && (tx_bit_q == TX_LAST) && (tx_byte_q == 3'd7);
  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign rx_stop = (state_q == S_RECV) && rx_active_q && (rx_bit_q == 4'd9) && bit_end;
  assign rx_last = rx_stop && (rx_byte_q == 2'd3);

`ifdef MATMUL_HOST_TIMEOUT_EN
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  logic [OW-1:0] to_cnt_q;
  logic          timeout_q;

  assign timeout_hit = (state_q == S_RECV) && (to_cnt_q == OW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (tx_done || rx_stop)
        to_cnt_q <= '0;
      else if (state_q == S_RECV)
        to_cnt_q <= to_cnt_q + OW'(1);
      if (state_q == S_IDLE && state_d == S_SEND)
        timeout_q <= 1'b0;
      else if (timeout_hit)
        timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid)           state_d = S_SEND;
      S_SEND:  if (tx_done)                 state_d = S_RECV;
      S_RECV:  if (rx_last || timeout_hit)  state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready)           state_d = S_IDLE;
      default:                              state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q     <= '0;
      tx_bit_q    <= '0;
      tx_byte_q   <= '0;
      tx_data_q   <= '0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_active_q <= 1'b0;
      rx_bit_q    <= '0;
      rx_sh_q     <= '0;
      rx_byte_q   <= '0;
      rsp_c_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      case (state_q)
        S_IDLE: begin
          if (state_d == S_SEND) begin
            tx_data_q   <= {bus.req_b, bus.req_a};
            rsp_c_q     <= '0;
            frame_err_q <= 1'b0;
          end
        end
        S_SEND: begin
          timer_q <= bit_end ? '0 : timer_q + TW'(1);
          if (bit_end) begin
            if (tx_bit_q == TX_LAST) begin
              tx_bit_q  <= '0;
              tx_byte_q <= tx_byte_q + 3'd1;
            end else begin
              tx_bit_q <= tx_bit_q + XW'(1);
            end
          end
        end
        S_RECV: begin
          if (!rx_active_q) begin
            if (rx_fall) begin
              rx_active_q <= 1'b1;
              timer_q     <= '0;
              rx_bit_q    <= '0;
            end
          end else if (rx_bit_q == 4'd0) begin
            // Start bit must still be low half a bit later, otherwise re-arm.
            if (timer_q == HALF_LAST) begin
              timer_q <= '0;
              if (rx_s2_q) rx_active_q <= 1'b0;
              else         rx_bit_q    <= 4'd1;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end else if (bit_end) begin
            timer_q <= '0;
            if (rx_bit_q == 4'd9) begin
              rsp_c_q[{rx_byte_q, 3'b000} +: 8] <= rx_sh_q;
              frame_err_q <= frame_err_q | ~rx_s2_q;
              rx_byte_q   <= rx_byte_q + 2'd1;
              rx_active_q <= 1'b0;
            end else begin
              rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
              rx_bit_q <= rx_bit_q + 4'd1;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: ;
      endcase
      if (tx_done) begin
        timer_q     <= '0;
        rx_active_q <= 1'b0;
      end
      if (state_q != S_IDLE && state_d == S_IDLE) begin
        timer_q     <= '0;
        tx_bit_q    <= '0;
        tx_byte_q   <= '0;
        rx_byte_q   <= '0;
        rx_bit_q    <= '0;
        rx_active_q <= 1'b0;
      end
    end
  end

  always_comb begin
    cur_byte          = tx_data_q[{tx_byte_q, 3'b000} +: 8];
    uart_tx           = 1'b1;
    busy              = (state_q != S_IDLE);
    bus.req_ready     = (state_q == S_IDLE);
    bus.rsp_valid     = (state_q == S_RESP);
    bus.rsp_c         = rsp_c_q;
    bus.rsp_frame_err = frame_err_q;
`ifdef MATMUL_HOST_TIMEOUT_EN
    bus.rsp_timeout   = timeout_q;
`else
    bus.rsp_timeout   = 1'b0;
`endif
    if (state_q == S_SEND) begin
      if (tx_bit_q == '0)
        uart_tx = 1'b0;
      else if (tx_bit_q <= XW'(8))
        uart_tx = cur_byte[3'(tx_bit_q - XW'(1))];
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_matmul_uart_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_matmul_uart_host : directed + randomised bench with accelerator model  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_matmul_uart_host;
  localparam int CPB   = 4;
  localparam int GAP   = 1;
  localparam int TO    = 200;
  localparam int FRAME = (10 + GAP) * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx;
  logic uart_rx = 1'b1;
  logic busy;

  matmul_uart_host_if bus();

  matmul_uart_host #(
    .CLKS_PER_BIT(CPB), .TX_GAP_BITS(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .uart_tx(uart_tx), .uart_rx(uart_rx), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int unsigned hs_cyc = 0;
  logic [7:0]  tx_q[$];
  int unsigned tx_t[$];

  // Decodes every frame the host puts on uart_tx, sampling at bit centres.
  initial begin
    logic [7:0]  d;
    int unsigned t;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_tx === 1'b0) begin
        t = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          d[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        tx_q.push_back(d);
        tx_t.push_back(t);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 2x2 product mod 256; byte 2r+c of a word is element (r,c).
  function automatic logic [31:0] mm_ref(input logic [31:0] a, input logic [31:0] b);
    int am [2][2];
    int bm [2][2];
    int s;
    logic [31:0] c;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) begin
        am[r][k] = int'(a[8*(2*r+k) +: 8]);
        bm[r][k] = int'(b[8*(2*r+k) +: 8]);
      end
    c = '0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) begin
        s = am[r][0] * bm[0][k] + am[r][1] * bm[1][k];
        c[8*(2*r+k) +: 8] = 8'(s % 256);
      end
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    tx_q.delete();
    tx_t.delete();
    bus.req_a = a;
    bus.req_b = b;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
    hs_cyc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("tx_byte_count", tx_q.size(), n);
  endtask

  // Accelerator model: checks the operand stream, then answers with its product.
  task automatic reply(input logic [31:0] a, input logic [31:0] b, input int bad_idx, input bit glitch);
    logic [63:0] ab;
    logic [63:0] rx_ab;
    logic [31:0] c;
    ab = {b, a};
    rx_ab = '0;
    wait_tx(8);
    if (tx_q.size() >= 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("tx_byte", {24'd0, tx_q[k]}, {24'd0, ab[8*k +: 8]});
        rx_ab[8*k +: 8] = tx_q[k];
      end
      chk("first_start_latency", tx_t[0] - hs_cyc, 32'd1);
      for (int k = 1; k < 8; k++)
        chk("frame_spacing", tx_t[k] - tx_t[k-1], FRAME);
    end
    c = mm_ref(rx_ab[31:0], rx_ab[63:32]);
    repeat (2 * CPB) @(negedge clk);
    if (glitch) begin
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (10) @(negedge clk);
    end
    for (int k = 0; k < 4; k++)
      send_byte(c[8*k +: 8], k != bad_idx);
  endtask

  task automatic wait_rsp(input int limit);
    int k = 0;
    while (bus.rsp_valid !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_valid_wait", {31'd0, bus.rsp_valid}, 32'd1);
  endtask

  task automatic check_rsp(input logic [31:0] exp_c, input logic exp_fe, input logic exp_to);
    chk("rsp_c", bus.rsp_c, exp_c);
    chk("rsp_frame_err", {31'd0, bus.rsp_frame_err}, {31'd0, exp_fe});
    chk("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, exp_to});
  endtask

  task automatic finish_rsp();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("idle_after_rsp", {31'd0, bus.req_ready}, 32'd1);
    chk("rsp_dropped", {31'd0, bus.rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    int seen;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;

    repeat (4) @(negedge clk);
    chk("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("reset_rsp_c", bus.rsp_c, 32'd0);
    chk("reset_frame_err", {31'd0, bus.rsp_frame_err}, 32'd0);
    chk("reset_timeout", {31'd0, bus.rsp_timeout}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed transaction with bit timing and backpressure.
    a = 32'h04030201;
    b = 32'h08070605;
    do_req(a, b);
    for (int i = 0; i < 6; i++) begin
      chk("start_bit_timing", {31'd0, uart_tx}, (i < 4) ? 32'd0 : 32'd1);
      @(negedge clk);
    end
    chk("busy_in_send", {31'd0, busy}, 32'd1);
    chk("req_ready_in_send", {31'd0, bus.req_ready}, 32'd0);
    reply(a, b, -1, 1'b0);
    wait_rsp(500);
    check_rsp(32'h322B1613, 1'b0, 1'b0);
    chk("model_directed", mm_ref(a, b), 32'h322B1613);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rsp_c", bus.rsp_c, 32'h322B1613);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    finish_rsp();

    // Random operands; the first also has a stray byte injected during SEND.
    for (int t = 0; t < 4; t++) begin
      a = $urandom();
      b = $urandom();
      do_req(a, b);
      if (t == 0) send_byte(8'($urandom_range(0, 255)), 1'b1);
      reply(a, b, -1, t == 1);
      wait_rsp(500);
      check_rsp(mm_ref(a, b), 1'b0, 1'b0);
      finish_rsp();
    end

    // Bad stop bit on result byte 1: stored anyway, flag raised.
    a = $urandom();
    b = $urandom();
    do_req(a, b);
    reply(a, b, 1, 1'b0);
    wait_rsp(500);
    check_rsp(mm_ref(a, b), 1'b1, 1'b0);
    finish_rsp();

`ifdef MATMUL_HOST_TIMEOUT_EN
    a = $urandom();
    b = $urandom();
    do_req(a, b);
    wait_tx(8);
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    wait_rsp(2000);
    check_rsp(32'h0000BBAA, 1'b0, 1'b1);
    finish_rsp();
`endif

    // Reset after three operand bytes, then a normal transaction.
    a = $urandom();
    b = $urandom();
    do_req(a, b);
    wait_tx(3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("abort_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || uart_tx !== 1'b1) seen++;
    end
    chk("abort_quiet", seen, 32'd0);
    a = $urandom();
    b = $urandom();
    do_req(a, b);
    reply(a, b, -1, 1'b0);
    wait_rsp(500);
    check_rsp(mm_ref(a, b), 1'b0, 1'b0);
    finish_rsp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
